// File: rtl/exec_ctrl.sv
// exec_ctrl: sequences one instruction at a time through condition check,
// decode, execute (or multiply wait) and write-back.
//
// Handshake: an instruction transfers on a rising clk edge where instr_valid
// and instr_ready are both high; instr_ready is high only in IDLE, so at most
// one instruction is in flight and instr_valid is ignored everywhere else.
//
// All control outputs are decoded from the registered state, the latched
// instruction, the multiply cycle counter and the flags/mult_done inputs;
// nothing depends on instr_valid.
module exec_ctrl #(
    parameter int MULT_MAX_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instruction,
    output logic        instr_ready,
    input  logic [3:0]  flags,
    input  logic        mult_done,
    output logic        dec_active,
    output logic        alu_en,
    output logic        reg_w_en,
    output logic        flags_w_en,
    output logic        wb_hi,
    output logic        pc_inc,
    output logic        skipped,
    output logic        mult_timeout,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COND      = 3'd1,
        S_DECODE    = 3'd2,
        S_EXEC      = 3'd3,
        S_MULT_WAIT = 3'd4,
        S_WB_HI     = 3'd5,
        S_WB        = 3'd6
    } state_t;

    // Counter value seen in the last permitted MULT_WAIT cycle.
    localparam logic [3:0] MULT_LAST = 4'(MULT_MAX_CYCLES - 1);

    state_t      cur_state;
    state_t      nxt_state;
    logic [31:0] instr_q;
    logic [3:0]  mult_cnt;

    logic        accept;
    logic        cond_pass;
    logic        is_mult;
    logic        is_long;
    logic        is_test_op;
    logic        mult_last;

    // Flag aliases for readability of the condition table.
    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;

    // Instruction fields that do not influence control sequencing.
    logic        unused_instr_bits;

    assign flag_n = flags[3];
    assign flag_z = flags[2];
    assign flag_c = flags[1];
    assign flag_v = flags[0];

    assign accept     = (cur_state == S_IDLE) && instr_valid;
    assign is_mult    = (instr_q[27:24] == 4'b0000) && (instr_q[7:4] == 4'b1001);
    assign is_long    = instr_q[23];
    // Opcodes 1000..1011 (TST, TEQ, CMP, CMN) only update flags.
    assign is_test_op = !is_mult && (instr_q[24:23] == 2'b10);
    assign mult_last  = (mult_cnt == MULT_LAST);

    assign unused_instr_bits = ^{instr_q[19:8], instr_q[3:0]};

    assign state = cur_state;

    // ARM condition field evaluation against the live N,Z,C,V flags.
    always_comb begin
        cond_pass = 1'b0;
        case (instr_q[31:28])
            4'b0000: cond_pass = flag_z;                          // EQ
            4'b0001: cond_pass = !flag_z;                         // NE
            4'b0010: cond_pass = flag_c;                          // CS/HS
            4'b0011: cond_pass = !flag_c;                         // CC/LO
            4'b0100: cond_pass = flag_n;                          // MI
            4'b0101: cond_pass = !flag_n;                         // PL
            4'b0110: cond_pass = flag_v;                          // VS
            4'b0111: cond_pass = !flag_v;                         // VC
            4'b1000: cond_pass = flag_c && !flag_z;               // HI
            4'b1001: cond_pass = !flag_c || flag_z;               // LS
            4'b1010: cond_pass = (flag_n == flag_v);              // GE
            4'b1011: cond_pass = (flag_n != flag_v);              // LT
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);   // GT
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);    // LE
            4'b1110: cond_pass = 1'b1;                            // AL
            default: cond_pass = 1'b0;                            // 1111 never executes
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Instruction latch: loads only on an accepted handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= 32'd0;
        end else if (accept) begin
            instr_q <= instruction;
        end
    end

    // Multiply wait counter: held at 0 outside MULT_WAIT so it starts at 0 on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mult_cnt <= 4'd0;
        end else if (cur_state != S_MULT_WAIT) begin
            mult_cnt <= 4'd0;
        end else begin
            mult_cnt <= mult_cnt + 4'd1;
        end
    end

    // Next-state selection.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE: begin
                if (accept) begin
                    nxt_state = S_COND;
                end
            end
            S_COND: begin
                nxt_state = cond_pass ? S_DECODE : S_IDLE;
            end
            S_DECODE: begin
                nxt_state = is_mult ? S_MULT_WAIT : S_EXEC;
            end
            S_EXEC: begin
                nxt_state = S_WB;
            end
            S_MULT_WAIT: begin
                // A completing multiply wins over a timeout in the same cycle.
                if (mult_done) begin
                    nxt_state = is_long ? S_WB_HI : S_WB;
                end else if (mult_last) begin
                    nxt_state = S_IDLE;
                end
            end
            S_WB_HI: begin
                nxt_state = S_WB;
            end
            S_WB: begin
                nxt_state = S_IDLE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // Output decode from state, latched instruction and counter.
    always_comb begin
        instr_ready  = 1'b0;
        dec_active   = 1'b0;
        alu_en       = 1'b0;
        reg_w_en     = 1'b0;
        flags_w_en   = 1'b0;
        wb_hi        = 1'b0;
        pc_inc       = 1'b0;
        skipped      = 1'b0;
        mult_timeout = 1'b0;
        case (cur_state)
            S_IDLE: begin
                instr_ready = 1'b1;
            end
            S_COND: begin
                // A failed condition retires the instruction with no writes.
                pc_inc  = !cond_pass;
                skipped = !cond_pass;
            end
            S_DECODE: begin
                dec_active = 1'b1;
            end
            S_EXEC: begin
                alu_en = 1'b1;
            end
            S_MULT_WAIT: begin
                alu_en       = 1'b1;
                mult_timeout = !mult_done && mult_last;
            end
            S_WB_HI: begin
                reg_w_en = 1'b1;
                wb_hi    = 1'b1;
            end
            S_WB: begin
                reg_w_en   = !is_test_op;
                flags_w_en = instr_q[20];
                pc_inc     = 1'b1;
            end
            default: begin
                instr_ready = 1'b0;
            end
        endcase
    end

endmodule
